// File: rtl/i2c_pkg.sv
// Shared state type and bus constants for the single-transaction I2C master.
package i2c_pkg;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_A,
        S_DATA,
        S_ACK_D,
        S_STOP,
        S_DONE
    } i2c_mst_state_e;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period timebase: divides clk by CLK_DIV and tracks the quarter index
// within an SCL bit slot. A held counter freezes time for clock stretching.
module i2c_qtr_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_hold,
    output logic       o_tick,
    output logic [1:0] o_qtr
);

    logic [7:0] r_count;
    logic [1:0] r_qtr;
    logic       w_wrap;

    assign w_wrap = (r_count == 8'(CLK_DIV - 1));
    assign o_tick = i_run && !i_hold && w_wrap;
    assign o_qtr  = r_qtr;

    // Idle periods keep the timebase cleared so every transaction starts at Q0.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_count <= '0;
            r_qtr   <= '0;
        end else if (o_tick) begin
            r_count <= '0;
            r_qtr   <= r_qtr + 2'd1;
        end else if (!i_hold) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/i2c_master_seq.sv
// Single-transaction I2C master: START, address+R/W, ACK, one data byte,
// ACK/NACK, STOP, then a one-cycle response with read data and error flag.
module i2c_master_seq
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [I2C_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [I2C_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  scl_oe,
    output logic                  sda_oe,
    input  logic                  scl_i,
    input  logic                  sda_i
);

    i2c_mst_state_e        r_state;
    logic                  r_scl_oe;
    logic                  r_sda_oe;
    logic                  r_rsp_valid;
    logic [I2C_DATA_W-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [7:0]            r_shift;
    logic [I2C_DATA_W-1:0] r_wdata;
    logic [I2C_DATA_W-1:0] r_rx;
    logic                  r_rw;
    logic                  r_err;
    logic [2:0]            r_bit;

    logic                  w_run;
    logic                  w_hold;
    logic                  w_tick;
    logic [1:0]            w_qtr;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_run  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_hold = (w_qtr == 2'd2) && !scl_i;

    i2c_qtr_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_run),
        .i_hold (w_hold),
        .o_tick (w_tick),
        .o_qtr  (w_qtr)
    );

    // Each tick moves into the next quarter; w_qtr is the quarter now ending,
    // so the bus outputs are set for the quarter being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_shift     <= '0;
            r_wdata     <= '0;
            r_rx        <= '0;
            r_rw        <= 1'b0;
            r_err       <= 1'b0;
            r_bit       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= S_START;
                        r_shift <= {cmd_addr, cmd_rw};
                        r_wdata <= cmd_wdata;
                        r_rw    <= cmd_rw;
                        r_rx    <= '0;
                        r_err   <= 1'b0;
                        r_bit   <= '0;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (w_tick) begin
                        case (w_qtr)
                            2'd0: begin
                                if (r_state == S_START) r_sda_oe <= 1'b1;
                            end
                            2'd1: r_scl_oe <= 1'b0;
                            2'd2: begin
                                if (r_state == S_STOP) r_sda_oe <= 1'b0;
                                if ((r_state == S_ACK_A || (r_state == S_ACK_D && !r_rw))
                                    && sda_i != I2C_ACK)
                                    r_err <= 1'b1;
                                if (r_state == S_DATA && r_rw) r_rx <= {r_rx[6:0], sda_i};
                            end
                            default: begin
                                r_scl_oe <= 1'b1;
                                case (r_state)
                                    S_START: begin
                                        r_state  <= S_ADDR;
                                        r_sda_oe <= ~r_shift[7];
                                    end
                                    S_ADDR: begin
                                        r_bit <= r_bit + 3'd1;
                                        if (r_bit == 3'd7) begin
                                            r_state  <= S_ACK_A;
                                            r_sda_oe <= 1'b0;
                                        end else begin
                                            r_shift  <= {r_shift[6:0], 1'b0};
                                            r_sda_oe <= ~r_shift[6];
                                        end
                                    end
                                    S_ACK_A: begin
                                        if (r_err) begin
                                            r_state  <= S_STOP;
                                            r_sda_oe <= 1'b1;
                                        end else begin
                                            r_state  <= S_DATA;
                                            r_shift  <= r_wdata;
                                            r_sda_oe <= !r_rw && !r_wdata[7];
                                        end
                                    end
                                    S_DATA: begin
                                        r_bit <= r_bit + 3'd1;
                                        if (r_bit == 3'd7) begin
                                            // Released SDA: the slave ACKs a write, the master NACKs a read.
                                            r_state  <= S_ACK_D;
                                            r_sda_oe <= ~I2C_NACK;
                                        end else begin
                                            r_shift  <= {r_shift[6:0], 1'b0};
                                            r_sda_oe <= !r_rw && !r_shift[6];
                                        end
                                    end
                                    S_ACK_D: begin
                                        r_state  <= S_STOP;
                                        r_sda_oe <= 1'b1;
                                    end
                                    S_STOP: begin
                                        r_state     <= S_DONE;
                                        r_scl_oe    <= 1'b0;
                                        r_rsp_valid <= 1'b1;
                                        r_rsp_err   <= r_err;
                                        r_rsp_rdata <= (r_rw && !r_err) ? r_rx : '0;
                                    end
                                    default: r_state <= S_IDLE;
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a small bus-level slave model driving
// ACKs, read data and clock stretching on the open-drain lines.
module tb_i2c_master_seq;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic [6:0] cmdAddr;
    logic       cmdRw;
    logic [7:0] cmdWdata;
    logic       rspValid;
    logic [7:0] rspRdata;
    logic       rspErr;
    logic       busy;
    logic       sclOe;
    logic       sdaOe;
    logic       sclLine;
    logic       sdaLine;

    logic       slaveSclLow;
    logic       slaveSdaLow;
    logic       slaveAckEn;
    logic [7:0] slaveRdata;
    logic [7:0] capAddr;
    logic [7:0] capData;
    logic       capAckD;
    logic       stopSeen;
    logic       prevScl;
    logic       prevSda;
    int         riseCnt;
    int         cyc;
    int         nCompared;
    int         nMismatched;

    assign sclLine = !(sclOe || slaveSclLow);
    assign sdaLine = !(sdaOe || slaveSdaLow);

    i2c_master_seq #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_addr  (cmdAddr),
        .cmd_rw    (cmdRw),
        .cmd_wdata (cmdWdata),
        .rsp_valid (rspValid),
        .rsp_rdata (rspRdata),
        .rsp_err   (rspErr),
        .busy      (busy),
        .scl_oe    (sclOe),
        .sda_oe    (sdaOe),
        .scl_i     (sclLine),
        .sda_i     (sdaLine)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: watches the lines each negedge, captures bits on SCL rise,
    // and changes its SDA drive only after SCL falls.
    initial begin
        logic s;
        logic d;
        riseCnt = 0;
        slaveSdaLow = 1'b0;
        stopSeen = 1'b0;
        capAddr = '0;
        capData = '0;
        capAckD = 1'b0;
        prevScl = 1'b1;
        prevSda = 1'b1;
        forever begin
            @(negedge clk);
            s = sclLine;
            d = sdaLine;
            if (rst) begin
                riseCnt = 0;
                slaveSdaLow = 1'b0;
                stopSeen = 1'b0;
                prevScl = 1'b1;
                prevSda = 1'b1;
            end else begin
                if (prevScl && s && prevSda && !d) begin
                    riseCnt = 0;
                    stopSeen = 1'b0;
                end
                if (prevScl && s && !prevSda && d) stopSeen = 1'b1;
                if (!prevScl && s) begin
                    riseCnt++;
                    if (riseCnt <= 8) capAddr = {capAddr[6:0], d};
                    else if (riseCnt >= 10 && riseCnt <= 17) capData = {capData[6:0], d};
                    else if (riseCnt == 18) capAckD = d;
                end
                if (prevScl && !s) begin
                    if (riseCnt == 8) slaveSdaLow = slaveAckEn;
                    else if (riseCnt >= 9 && riseCnt <= 16)
                        slaveSdaLow = slaveAckEn && capAddr[0] && !slaveRdata[16 - riseCnt];
                    else if (riseCnt == 17) slaveSdaLow = !capAddr[0];
                    else slaveSdaLow = 1'b0;
                end
                prevScl = s;
                prevSda = d;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called in the #1-after-posedge phase; returns the accepting edge number.
    task automatic applyStimulus(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                                 input bit keep, output int tAcc);
        logic rdy;
        cmdAddr  = addr;
        cmdRw    = rw;
        cmdWdata = wdata;
        cmdValid = 1'b1;
        tAcc = -1;
        for (int i = 0; i < 64 && tAcc < 0; i++) begin
            rdy = cmdReady;
            @(posedge clk);
            #1;
            if (rdy) tAcc = cyc;
        end
        if (!keep) cmdValid = 1'b0;
        checkOutput("accept", 32'(tAcc >= 0), 32'd1);
    endtask

    task automatic waitRsp(output int tRsp);
        tRsp = -1;
        for (int i = 0; i < 2000 && tRsp < 0; i++) begin
            @(posedge clk);
            #1;
            if (rspValid) tRsp = cyc;
        end
    endtask

    initial begin
        int   tAcc;
        int   tRsp;
        int   tAcc2;
        int   tRsp2;
        int   glitch;
        logic rdy;
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b1;
        cmdValid    = 1'b0;
        cmdAddr     = '0;
        cmdRw       = 1'b0;
        cmdWdata    = '0;
        slaveSclLow = 1'b0;
        slaveAckEn  = 1'b1;
        slaveRdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_scl_oe", 32'(sclOe), 32'd0);
        checkOutput("rst_sda_oe", 32'(sdaOe), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rspRdata), 32'h0);
        checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);

        // Write 0x5A to 0x42, both bytes ACKed.
        applyStimulus(7'h42, 1'b0, 8'h5A, 1'b0, tAcc);
        waitRsp(tRsp);
        checkOutput("wr_latency", 32'(tRsp - tAcc), 32'(80 * D));
        checkOutput("wr_addr_byte", 32'(capAddr), 32'h84);
        checkOutput("wr_data_byte", 32'(capData), 32'h5A);
        checkOutput("wr_err", 32'(rspErr), 32'd0);
        checkOutput("wr_rdata", 32'(rspRdata), 32'h0);
        checkOutput("wr_stop", 32'(stopSeen), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wr_valid_pulse", 32'(rspValid), 32'd0);
        checkOutput("wr_busy_after", 32'(busy), 32'd0);

        // Read from 0x42, slave returns 0xC3, master NACKs.
        slaveRdata = 8'hC3;
        applyStimulus(7'h42, 1'b1, 8'hFF, 1'b0, tAcc);
        waitRsp(tRsp);
        checkOutput("rd_latency", 32'(tRsp - tAcc), 32'(80 * D));
        checkOutput("rd_addr_byte", 32'(capAddr), 32'h85);
        checkOutput("rd_rdata", 32'(rspRdata), 32'hC3);
        checkOutput("rd_err", 32'(rspErr), 32'd0);
        checkOutput("rd_master_nack", 32'(capAckD), 32'd1);
        checkOutput("rd_stop", 32'(stopSeen), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rd_rdata_hold", 32'(rspRdata), 32'hC3);

        // Address 0x10 read, nobody ACKs.
        slaveAckEn = 1'b0;
        applyStimulus(7'h10, 1'b1, 8'h00, 1'b0, tAcc);
        waitRsp(tRsp);
        checkOutput("nack_latency", 32'(tRsp - tAcc), 32'(44 * D));
        checkOutput("nack_err", 32'(rspErr), 32'd1);
        checkOutput("nack_rdata", 32'(rspRdata), 32'h0);
        checkOutput("nack_addr_byte", 32'(capAddr), 32'h21);
        checkOutput("nack_scl_rises", 32'(riseCnt), 32'd10);
        checkOutput("nack_stop", 32'(stopSeen), 32'd1);
        slaveAckEn = 1'b1;

        // Stretch SCL for 37 cycles in the fifth address slot.
        applyStimulus(7'h42, 1'b0, 8'h3C, 1'b0, tAcc);
        for (int i = 0; i < 1000 && !(riseCnt == 4 && sclOe); i++) begin
            @(posedge clk);
            #1;
        end
        slaveSclLow = 1'b1;
        for (int i = 0; i < 100 && sclOe; i++) begin
            @(posedge clk);
            #1;
        end
        glitch = 0;
        repeat (37) begin
            @(posedge clk);
            #1;
            if (sclOe) glitch++;
        end
        slaveSclLow = 1'b0;
        checkOutput("st_frozen", 32'(glitch), 32'd0);
        waitRsp(tRsp);
        checkOutput("st_latency", 32'(tRsp - tAcc), 32'(80 * D + 37));
        checkOutput("st_addr_byte", 32'(capAddr), 32'h84);
        checkOutput("st_data_byte", 32'(capData), 32'h3C);
        checkOutput("st_err", 32'(rspErr), 32'd0);

        // Back-to-back: cmd_valid stays high across two transactions.
        applyStimulus(7'h42, 1'b0, 8'h11, 1'b1, tAcc);
        waitRsp(tRsp);
        checkOutput("b2b_latency1", 32'(tRsp - tAcc), 32'(80 * D));
        cmdWdata = 8'h22;
        tAcc2 = -1;
        glitch = 0;
        for (int i = 0; i < 16 && tAcc2 < 0; i++) begin
            rdy = cmdReady;
            @(posedge clk);
            #1;
            if (sclOe) glitch++;
            if (rdy) tAcc2 = cyc;
        end
        cmdValid = 1'b0;
        checkOutput("b2b_accept_gap", 32'(tAcc2 - tRsp), 32'd2);
        repeat (D + 1) begin
            @(posedge clk);
            #1;
            if (sclOe) glitch++;
        end
        checkOutput("b2b_scl_glitch", 32'(glitch), 32'd0);
        checkOutput("b2b_start_sda", 32'(sdaOe), 32'd1);
        waitRsp(tRsp2);
        checkOutput("b2b_latency2", 32'(tRsp2 - tAcc2), 32'(80 * D));
        checkOutput("b2b_data_byte", 32'(capData), 32'h22);

        // Reset pulsed during DATA bit 4, then a normal write.
        applyStimulus(7'h42, 1'b0, 8'h99, 1'b0, tAcc);
        for (int i = 0; i < 1000 && riseCnt < 13; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_scl_oe", 32'(sclOe), 32'd0);
        checkOutput("mid_sda_oe", 32'(sdaOe), 32'd0);
        checkOutput("mid_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("mid_rsp_valid", 32'(rspValid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(7'h42, 1'b0, 8'h5A, 1'b0, tAcc);
        waitRsp(tRsp);
        checkOutput("post_latency", 32'(tRsp - tAcc), 32'(80 * D));
        checkOutput("post_data_byte", 32'(capData), 32'h5A);
        checkOutput("post_err", 32'(rspErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
